// File: rtl/shared_alu_pkg.sv
// Shared ALU scheduler package: opcodes, FSM states and the round-robin
// grant helper. SHARED_ALU_CLOG2_EN enables opcode 5 (CLOG2) in the scheduler.
package shared_alu_pkg;

  localparam int OPCODE_WIDTH   = 3;
  localparam int MAX_REQUESTERS = 16;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_DIV   = 3'd3,
    OP_MOD   = 3'd4,
    OP_CLOG2 = 3'd5
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    EXECUTE,
    RESPOND
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } grant_t;

  // First asserted valid at or above ptr, wrapping within n clients.
  function automatic grant_t rr_grant(input logic [MAX_REQUESTERS-1:0] valid,
                                      input logic [3:0] ptr,
                                      input int n);
    grant_t     g;
    logic [4:0] k;
    g = '0;
    for (int i = 0; i < MAX_REQUESTERS; i++) begin
      if (i < n) begin
        k = {1'b0, ptr} + 5'(i);
        if (k >= 5'(n)) k = k - 5'(n);
        if (!g.found && valid[k[3:0]]) begin
          g.found = 1'b1;
          g.idx   = k[3:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/shared_alu_scheduler_divider.sv
// Restoring divider: one quotient bit per clock, DATA_WIDTH clocks per
// division. done pulses for one cycle once quotient/remainder are final.
module iterative_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0]         count_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH:0]   shifted, diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Load on start, then shift in one quotient bit per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        rem_q   <= '0;
        quo_q   <= dividend;
        dvs_q   <= divisor;
        count_q <= CW'(DATA_WIDTH);
        busy_q  <= 1'b1;
      end else if (busy_q) begin
        if (!diff[DATA_WIDTH]) begin
          rem_q <= diff[DATA_WIDTH-1:0];
          quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DATA_WIDTH-1:0];
          quo_q <= {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
        count_q <= count_q - 1'b1;
        if (count_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/shared_alu_scheduler.sv
// Round-robin scheduler sharing one add/sub/mul/div/mod unit between clients.
// Define SHARED_ALU_CLOG2_EN to enable opcode 5 (ceil(log2(a))).
//
// state   | meaning
// IDLE    | granting the next requester (req_ready live for the grantee)
// EXECUTE | computing; divides wait here for the iterative divider
// RESPOND | resp_valid high, outputs held until resp_ready
module shared_alu_scheduler
  import shared_alu_pkg::*;
#(
  parameter int N_REQUESTERS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ID_WIDTH     = $clog2(N_REQUESTERS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [N_REQUESTERS-1:0]            req_valid,
  output logic [N_REQUESTERS-1:0]            req_ready,
  input  logic [OPCODE_WIDTH*N_REQUESTERS-1:0] req_opcode,
  input  logic [DATA_WIDTH*N_REQUESTERS-1:0] req_a,
  input  logic [DATA_WIDTH*N_REQUESTERS-1:0] req_b,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [ID_WIDTH-1:0]                resp_id,
  output logic [DATA_WIDTH-1:0]              resp_result,
  output logic                               resp_error
);

  state_e                    state_q, state_d;
  logic [ID_WIDTH-1:0]       ptr_q, id_q, sel_id;
  logic [OPCODE_WIDTH-1:0]   op_q, sel_op;
  logic [DATA_WIDTH-1:0]     a_q, b_q, sel_a, sel_b;
  logic [DATA_WIDTH-1:0]     result_q, alu_result, div_quo, div_rem;
  logic                      error_q, alu_error;
  logic                      div_start, div_busy, div_done, div_path;
  logic [MAX_REQUESTERS-1:0] valid_ext;
  grant_t                    gnt;

  assign valid_ext = MAX_REQUESTERS'(req_valid);
  assign gnt       = rr_grant(valid_ext, 4'(ptr_q), N_REQUESTERS);
  assign sel_id    = ID_WIDTH'(gnt.idx);
  assign sel_op    = req_opcode[int'(sel_id)*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign sel_a     = req_a[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_b     = req_b[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];

  // The divider is launched on the grant edge so its DATA_WIDTH steps overlap EXECUTE.
  assign div_start = (state_q == IDLE) && gnt.found &&
                     ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_b != '0);
  assign div_path  = ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q != '0);

  iterative_divider #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (sel_a),
    .divisor   (sel_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Ready only for the current grantee while idle and out of reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      req_ready[i] = reset && (state_q == IDLE) && gnt.found && (gnt.idx == 4'(i));
    end
  end

`ifdef SHARED_ALU_CLOG2_EN
  logic [DATA_WIDTH-1:0] a_m1, clog2_val;

  // ceil(log2(a)) is one past the leading one of a-1; a of 0 or 1 gives 0.
  always_comb begin
    a_m1      = a_q - 1'b1;
    clog2_val = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (a_m1[i]) clog2_val = DATA_WIDTH'(i + 1);
    end
    if (a_q == '0) clog2_val = '0;
  end
`endif

  // Single-cycle results, including the divide-by-zero shortcuts.
  always_comb begin
    alu_result = '0;
    alu_error  = 1'b0;
    case (op_q)
      OP_ADD: alu_result = a_q + b_q;
      OP_SUB: alu_result = a_q - b_q;
      OP_MUL: alu_result = a_q * b_q;
      OP_DIV: begin
        alu_result = '1;
        alu_error  = 1'b1;
      end
      OP_MOD: begin
        alu_result = a_q;
        alu_error  = 1'b1;
      end
`ifdef SHARED_ALU_CLOG2_EN
      OP_CLOG2: alu_result = clog2_val;
`endif
      default: alu_error = 1'b1;
    endcase
  end

  // Next state: divides hold EXECUTE while the divider is stepping.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt.found) state_d = EXECUTE;
      EXECUTE: if (!(div_path && div_busy)) state_d = RESPOND;
      RESPOND: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, captured request and registered result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt.found) begin
            id_q  <= sel_id;
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            ptr_q <= (sel_id == ID_WIDTH'(N_REQUESTERS - 1)) ? '0 : sel_id + 1'b1;
          end
        end
        EXECUTE: begin
          if (div_path) begin
            if (div_done) begin
              result_q <= (op_q == OP_MOD) ? div_rem : div_quo;
              error_q  <= 1'b0;
            end
          end else begin
            result_q <= alu_result;
            error_q  <= alu_error;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_valid  = (state_q == RESPOND);
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_error  = error_q;

endmodule
